// File: rtl/rcv_pkg.sv
// Shared receive-path definitions for the RRC slicer / MER block.
// Holds the Gray-coded 4-ASK symbol encodings, default ideal levels and
// decision threshold (all 1s17), and the sample / error / square widths.
package rcv_pkg;

  localparam int SAMP_W = 18;
  localparam int ERR_W  = 19;
  localparam int SQ_W   = 2 * ERR_W;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  localparam logic signed [SAMP_W-1:0] LVL_LO_DEF = 18'sd16384;
  localparam logic signed [SAMP_W-1:0] LVL_HI_DEF = 18'sd49152;
  localparam logic signed [SAMP_W-1:0] THRESH_DEF = 18'sd32768;

endpackage

// File: rtl/rcv_mer_acc.sv
// Error-power accumulator for the MER measurement.
// Squares each slicer error, sums the squares over 2^LOG2_N symbols and
// publishes the total on err_pwr with a one-cycle pwr_valid pulse.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   err          signed 2s17 slicer error (ERR_W bits)
//   err_valid    err carries a new symbol this cycle
//   clear_acc    drop the running measurement and restart it
//   err_pwr      unsigned sum of err^2 (4s34 LSB-aligned), held between updates
//   pwr_valid    one-cycle pulse when err_pwr is updated
module rcv_mer_acc
  import rcv_pkg::*;
#(
  parameter int LOG2_N = 10,
  parameter int ACC_W  = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ERR_W-1:0] err,
  input  logic             err_valid,
  input  logic             clear_acc,
  output logic [ACC_W-1:0] err_pwr,
  output logic             pwr_valid
);

  logic signed [ERR_W-1:0] err_p1;
  logic signed [SQ_W-1:0]  sq_full_p1;
  logic [SQ_W-1:0]         sq_p2;
  logic                    vld_p2;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_sum;
  logic [LOG2_N-1:0]       sym_cnt;

  assign err_p1     = $signed(err);
  // Both operands are sign-extended to SQ_W before the multiply, so the
  // product is exact and always non-negative.
  assign sq_full_p1 = err_p1 * err_p1;

  // ---- stage p1 -> p2: register the square ----
  always_ff @(posedge clk) begin
    sq_p2 <= sq_full_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= err_valid;
  end

  // ---- stage p2 -> p3: accumulate, count symbols, publish ----
  assign acc_sum = acc + ACC_W'(sq_p2);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      sym_cnt   <= '0;
      err_pwr   <= '0;
      pwr_valid <= 1'b0;
    end else begin
      pwr_valid <= 1'b0;
      if (clear_acc) begin
        // Clear beats a same-cycle square, including the completing one.
        acc     <= '0;
        sym_cnt <= '0;
      end else if (vld_p2) begin
        if (sym_cnt == '1) begin
          err_pwr   <= acc_sum;
          pwr_valid <= 1'b1;
          acc       <= '0;
          sym_cnt   <= '0;
        end else begin
          acc     <= acc_sum;
          sym_cnt <= sym_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rcv_slicer_mer.sv
// Symbol slicer and MER measurement behind the 21-tap receive RRC filter.
// Takes one sample per symbol at a programmable phase, slices it to a
// Gray-coded 4-ASK symbol, outputs the slicer error and accumulates the
// error power over 2^LOG2_N symbols.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   y_in         signed 1s17 filter output sample
//   sample_en    y_in valid this cycle
//   phase        sample index within the symbol used for the decision
//   clear_acc    abort the current error-power measurement
//   sym_out      sliced Gray symbol, held between decisions
//   sym_valid    one-cycle pulse, sym_out/err_out updated
//   err_out      signed 2s17 slicer error (y - ideal level)
//   err_pwr      sum of err^2 over the last completed measurement
//   pwr_valid    one-cycle pulse, err_pwr updated
module rcv_slicer_mer
  import rcv_pkg::*;
#(
  parameter int                      SPS    = 4,
  parameter int                      CNT_W  = 2,
  parameter logic signed [SAMP_W-1:0] LVL_LO = LVL_LO_DEF,
  parameter logic signed [SAMP_W-1:0] LVL_HI = LVL_HI_DEF,
  parameter logic signed [SAMP_W-1:0] THRESH = THRESH_DEF,
  parameter int                      LOG2_N = 10,
  parameter int                      ACC_W  = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SAMP_W-1:0] y_in,
  input  logic              sample_en,
  input  logic [CNT_W-1:0]  phase,
  input  logic              clear_acc,
  output logic [1:0]        sym_out,
  output logic              sym_valid,
  output logic [ERR_W-1:0]  err_out,
  output logic [ACC_W-1:0]  err_pwr,
  output logic              pwr_valid
);

  function automatic logic [1:0] slice_sym(input logic signed [SAMP_W-1:0] y);
    if (y >= THRESH)             return SYM_P3;
    else if (y >= 18'sd0)        return SYM_P1;
    else if (y >= -THRESH)       return SYM_M1;
    else                         return SYM_M3;
  endfunction

  function automatic logic signed [SAMP_W-1:0] slice_lvl(input logic signed [SAMP_W-1:0] y);
    if (y >= THRESH)             return LVL_HI;
    else if (y >= 18'sd0)        return LVL_LO;
    else if (y >= -THRESH)       return -LVL_LO;
    else                         return -LVL_HI;
  endfunction

  logic [CNT_W-1:0]         cnt;
  logic                     strobe_p0;
  logic signed [SAMP_W-1:0] y_p0;
  logic signed [SAMP_W-1:0] lvl_p0;
  logic signed [ERR_W-1:0]  err_p0;

  // Compare uses the pre-increment count; a phase change simply moves the
  // compare point, so one symbol may be skipped or repeated.
  assign strobe_p0 = sample_en && (cnt == phase);
  assign y_p0      = $signed(y_in);
  assign lvl_p0    = slice_lvl(y_p0);
  // One guard bit makes the subtraction overflow-free.
  assign err_p0    = $signed({y_p0[SAMP_W-1], y_p0}) - $signed({lvl_p0[SAMP_W-1], lvl_p0});

  // ---- stage p0 -> p1: decision register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sym_out   <= '0;
      err_out   <= '0;
      sym_valid <= 1'b0;
    end else begin
      if (sample_en) begin
        if (cnt == CNT_W'(SPS - 1)) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
      end
      sym_valid <= strobe_p0;
      if (strobe_p0) begin
        sym_out <= slice_sym(y_p0);
        err_out <= err_p0;
      end
    end
  end

  rcv_mer_acc #(
    .LOG2_N (LOG2_N),
    .ACC_W  (ACC_W)
  ) u_mer_acc (
    .clk       (clk),
    .reset     (reset),
    .err       (err_out),
    .err_valid (sym_valid),
    .clear_acc (clear_acc),
    .err_pwr   (err_pwr),
    .pwr_valid (pwr_valid)
  );

endmodule

// File: tb/tb_rcv_slicer_mer.sv
// Directed bench for rcv_slicer_mer with a 4-symbol measurement window.
module tb_rcv_slicer_mer;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] y_in;
  logic        sample_en;
  logic [1:0]  phase;
  logic        clear_acc;
  logic [1:0]  sym_out;
  logic        sym_valid;
  logic [18:0] err_out;
  logic [47:0] err_pwr;
  logic        pwr_valid;

  int errors = 0;
  int checks = 0;
  int pv_cnt = 0;

  always #5 clk = ~clk;

  rcv_slicer_mer #(
    .LOG2_N (2),
    .ACC_W  (48)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .sample_en (sample_en),
    .phase     (phase),
    .clear_acc (clear_acc),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .err_out   (err_out),
    .err_pwr   (err_pwr),
    .pwr_valid (pwr_valid)
  );

  always @(negedge clk) if (pwr_valid === 1'b1) pv_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; sample_en = 1'b0; clear_acc = 1'b0; y_in = '0;
    step;
    reset = 1'b0;
  endtask

  // One symbol period at phase 0: strobe sample y then three zero samples.
  task automatic send_sym(input int y, input logic [3:0] clr,
                          output logic [1:0] s, output int e,
                          output logic sv, output logic [3:0] pv);
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1;
      y_in      = (i == 0) ? y[17:0] : 18'd0;
      clear_acc = clr[i];
      step;
      if (i == 0) begin
        s  = sym_out;
        e  = $signed(err_out);
        sv = sym_valid;
      end
      pv[i] = pwr_valid;
    end
    sample_en = 1'b0;
    clear_acc = 1'b0;
  endtask

  int         ys   [8] = '{60000, 32768, 32767, 0, -1, -32768, -32769, -60000};
  int         esym [8] = '{2, 2, 3, 3, 1, 1, 0, 0};
  int         eerr [8] = '{10848, -16384, 16383, -16384, 16383, -16384, 16383, -10848};
  logic [1:0] s;
  int         e;
  logic       sv;
  logic [3:0] pv;
  logic       anyv;
  int         c0;

  initial begin
    reset = 1'b1; sample_en = 1'b0; y_in = '0; phase = '0; clear_acc = 1'b0;
    repeat (3) step;
    chk("rst_sym_out", sym_out, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_err_out", err_out, 0);
    chk("rst_err_pwr", err_pwr, 0);
    chk("rst_pwr_valid", pwr_valid, 0);
    reset = 1'b0;
    anyv = 1'b0;
    repeat (20) begin
      step;
      if (sym_valid || pwr_valid) anyv = 1'b1;
    end
    chk("idle_valids", anyv, 0);
    chk("idle_err_out", err_out, 0);
    chk("idle_err_pwr", err_pwr, 0);

    // Phase select: only samples 2, 6, 10 produce decisions.
    phase = 2'd2;
    for (int i = 0; i < 12; i++) begin
      sample_en = 1'b1;
      y_in = 18'(i);
      step;
      chk($sformatf("phase_sv%0d", i), sym_valid, (i % 4 == 2) ? 1 : 0);
      if (i % 4 == 2) begin
        chk($sformatf("phase_err%0d", i), $signed(err_out), i - 16384);
        chk($sformatf("phase_sym%0d", i), sym_out, 3);
      end
    end
    sample_en = 1'b0;
    phase = 2'd0;

    // Slicer decision points and boundaries.
    for (int k = 0; k < 8; k++) begin
      send_sym(ys[k], 4'b0000, s, e, sv, pv);
      chk($sformatf("slice_sv%0d", k), sv, 1);
      chk($sformatf("slice_sym%0d", k), s, esym[k]);
      chk($sformatf("slice_err%0d", k), e, eerr[k]);
    end

    // Power accumulation over 4 symbols, then a zero-error window.
    do_reset;
    for (int k = 0; k < 4; k++) begin
      send_sym(20000, 4'b0000, s, e, sv, pv);
      chk($sformatf("pwr_pv%0d", k), pv, (k == 3) ? 4 : 0);
    end
    chk("pwr_value", err_pwr, 64'd52301824);
    for (int k = 0; k < 4; k++) begin
      send_sym(16384, 4'b0000, s, e, sv, pv);
      if (k == 2) chk("pwr_hold", err_pwr, 64'd52301824);
    end
    chk("pwr_zero_pv", pv, 4);
    chk("pwr_zero", err_pwr, 0);

    // clear_acc between symbols restarts the window.
    do_reset;
    c0 = pv_cnt;
    for (int k = 0; k < 2; k++) send_sym(20000, 4'b0000, s, e, sv, pv);
    clear_acc = 1'b1;
    step;
    clear_acc = 1'b0;
    for (int k = 0; k < 4; k++) send_sym(16484, 4'b0000, s, e, sv, pv);
    chk("clr_pv", pv, 4);
    chk("clr_pulses", pv_cnt - c0, 1);
    chk("clr_value", err_pwr, 64'd40000);

    // clear_acc on the completion cycle wins.
    for (int k = 0; k < 3; k++) send_sym(20000, 4'b0000, s, e, sv, pv);
    send_sym(20000, 4'b0100, s, e, sv, pv);
    chk("coll_pv", pv, 0);
    chk("coll_hold", err_pwr, 64'd40000);
    for (int k = 0; k < 4; k++) send_sym(16584, 4'b0000, s, e, sv, pv);
    chk("coll_next_pv", pv, 4);
    chk("coll_next_value", err_pwr, 64'd160000);

    // Reset in the middle of a measurement, with a symbol in flight.
    for (int k = 0; k < 2; k++) send_sym(20000, 4'b0000, s, e, sv, pv);
    sample_en = 1'b1; y_in = 18'd20000;
    step;
    chk("mid_sv", sym_valid, 1);
    reset = 1'b1; sample_en = 1'b0; y_in = '0;
    step;
    chk("mid_rst_sv", sym_valid, 0);
    chk("mid_rst_sym", sym_out, 0);
    chk("mid_rst_err", err_out, 0);
    chk("mid_rst_pwr", err_pwr, 0);
    chk("mid_rst_pv", pwr_valid, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_sym(16484, 4'b0000, s, e, sv, pv);
      if (k == 2) chk("mid_after_pv2", pv, 0);
    end
    chk("mid_after_pv3", pv, 4);
    chk("mid_after_value", err_pwr, 64'd40000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
